// File: rtl/arbiter_multi_mode_if.sv
// Request/grant bus between a set of requesters and arbiter_multi_mode.
// master: requester side, drives requests and end-of-access pulses.
// slave : arbiter side, drives the one-hot grant, its index and the timeout pulse.
interface arbiter_multi_mode_if #(
  parameter int N = 4
);
  localparam int IDW = $clog2(N);

  logic [N-1:0]   i_req_vector;
  logic [N-1:0]   i_end_access_vector;
  logic [N-1:0]   o_grant_vector;
  logic           o_grant_valid;
  logic [IDW-1:0] o_grant_id;
  logic           o_timeout;

  modport master (
    output i_req_vector, i_end_access_vector,
    input  o_grant_vector, o_grant_valid, o_grant_id, o_timeout
  );

  modport slave (
    input  i_req_vector, i_end_access_vector,
    output o_grant_vector, o_grant_valid, o_grant_id, o_timeout
  );
endinterface

// File: rtl/arbiter_multi_mode.sv
// N-way arbiter, strict priority (MODE=0) or round-robin (MODE=1), optional grant-hold timeout.
// Latency: grant registered one edge after a request is seen; back-to-back regrant on release.
// Backpressure: a grant is held until the owner pulses end-of-access or the timeout expires.
// Ports: i_clk, i_rst (async, active-low), bus (slave modport: requests in, grant/timeout out).
module arbiter_multi_mode #(
  parameter int N       = 4,
  parameter int MODE    = 0,
  parameter int TIMEOUT = 0
) (
  input logic                 i_clk,
  input logic                 i_rst,
  arbiter_multi_mode_if.slave bus
);
  localparam int IDW = $clog2(N);
  // Counter only has to reach TIMEOUT-1.
  localparam int CW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TLIM = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  // One-hot state encoding so the unused codes (00, 11) are recoverable.
  typedef enum logic [1:0] {
    IDLE  = 2'b01,
    GRANT = 2'b10
  } state_t;

  state_t         state;
  logic [N-1:0]   grant_vec;
  logic           grant_vld;
  logic [IDW-1:0] grant_id;
  logic [IDW-1:0] last_id;
  logic [CW-1:0]  hold_cnt;
  logic           timeout_pulse;

  logic [IDW-1:0] win_id;
  logic           win_found;
  logic           end_hit;
  logic           timeout_hit;
  logic           release_now;
  logic           arb_go;
  int             cand;

  // Winner search: strict scans from index 0, round-robin from last_id+1 with wrap.
  always_comb begin
    win_id    = '0;
    win_found = 1'b0;
    cand      = 0;
    for (int i = 0; i < N; i++) begin
      cand = (MODE == 1) ? ((int'(last_id) + 1 + i) % N) : i;
      if (!win_found && bus.i_req_vector[cand]) begin
        win_found = 1'b1;
        win_id    = IDW'(cand);
      end
    end
  end

  // Only the current owner's end bit counts.
  assign end_hit     = grant_vld && bus.i_end_access_vector[grant_id];
  assign timeout_hit = (TIMEOUT > 0) && (state == GRANT) && (hold_cnt == TLIM);
  assign release_now = (state == GRANT) && (end_hit || timeout_hit);
  assign arb_go      = win_found && ((state == IDLE) || release_now);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state         <= IDLE;
      grant_vec     <= '0;
      grant_vld     <= 1'b0;
      grant_id      <= '0;
      last_id       <= IDW'(N - 1);
      hold_cnt      <= '0;
      timeout_pulse <= 1'b0;
    end else begin
      timeout_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (arb_go) begin
            state     <= GRANT;
            grant_vec <= {{(N-1){1'b0}}, 1'b1} << win_id;
            grant_vld <= 1'b1;
            grant_id  <= win_id;
            last_id   <= win_id;
            hold_cnt  <= '0;
          end else begin
            grant_vec <= '0;
            grant_vld <= 1'b0;
            grant_id  <= '0;
          end
        end
        GRANT: begin
          // A coincident end-of-access makes it an ordinary release.
          if (timeout_hit && !end_hit) begin
            timeout_pulse <= 1'b1;
          end
          if (arb_go) begin
            grant_vec <= {{(N-1){1'b0}}, 1'b1} << win_id;
            grant_vld <= 1'b1;
            grant_id  <= win_id;
            last_id   <= win_id;
            hold_cnt  <= '0;
          end else if (!release_now) begin
            hold_cnt  <= hold_cnt + CW'(1);
          end else begin
            state     <= IDLE;
            grant_vec <= '0;
            grant_vld <= 1'b0;
            grant_id  <= '0;
            hold_cnt  <= '0;
          end
        end
        default: begin
          state     <= IDLE;
          grant_vec <= '0;
          grant_vld <= 1'b0;
          grant_id  <= '0;
          hold_cnt  <= '0;
        end
      endcase
    end
  end

  assign bus.o_grant_vector = grant_vec;
  assign bus.o_grant_valid  = grant_vld;
  assign bus.o_grant_id     = grant_id;
  assign bus.o_timeout      = timeout_pulse;
endmodule

// File: tb/tb_arbiter_multi_mode.sv
module tb_arbiter_multi_mode;
  logic clk;
  logic rst_n;

  // Four configurations: strict, round-robin, strict+TO8, round-robin+TO4.
  logic [3:0] req_d [4];
  logic [3:0] end_d [4];
  logic [3:0] gv    [4];
  logic       vld   [4];
  logic [1:0] gid   [4];
  logic       tmo   [4];

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: owner index (-1 none), cycles held, last winner.
  int   own  [4];
  int   held [4];
  int   last [4];
  logic mto  [4];

  arbiter_multi_mode_if #(.N(4)) if0 ();
  arbiter_multi_mode_if #(.N(4)) if1 ();
  arbiter_multi_mode_if #(.N(4)) if2 ();
  arbiter_multi_mode_if #(.N(4)) if3 ();

  arbiter_multi_mode #(.N(4), .MODE(0), .TIMEOUT(0)) dut0 (.i_clk(clk), .i_rst(rst_n), .bus(if0));
  arbiter_multi_mode #(.N(4), .MODE(1), .TIMEOUT(0)) dut1 (.i_clk(clk), .i_rst(rst_n), .bus(if1));
  arbiter_multi_mode #(.N(4), .MODE(0), .TIMEOUT(8)) dut2 (.i_clk(clk), .i_rst(rst_n), .bus(if2));
  arbiter_multi_mode #(.N(4), .MODE(1), .TIMEOUT(4)) dut3 (.i_clk(clk), .i_rst(rst_n), .bus(if3));

  assign if0.i_req_vector = req_d[0];
  assign if1.i_req_vector = req_d[1];
  assign if2.i_req_vector = req_d[2];
  assign if3.i_req_vector = req_d[3];
  assign if0.i_end_access_vector = end_d[0];
  assign if1.i_end_access_vector = end_d[1];
  assign if2.i_end_access_vector = end_d[2];
  assign if3.i_end_access_vector = end_d[3];
  assign gv[0] = if0.o_grant_vector;  assign vld[0] = if0.o_grant_valid;
  assign gv[1] = if1.o_grant_vector;  assign vld[1] = if1.o_grant_valid;
  assign gv[2] = if2.o_grant_vector;  assign vld[2] = if2.o_grant_valid;
  assign gv[3] = if3.o_grant_vector;  assign vld[3] = if3.o_grant_valid;
  assign gid[0] = if0.o_grant_id;     assign tmo[0] = if0.o_timeout;
  assign gid[1] = if1.o_grant_id;     assign tmo[1] = if1.o_timeout;
  assign gid[2] = if2.o_grant_id;     assign tmo[2] = if2.o_timeout;
  assign gid[3] = if3.o_grant_id;     assign tmo[3] = if3.o_timeout;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int mode_of(input int k);
    return (k == 1 || k == 3) ? 1 : 0;
  endfunction

  function automatic int to_of(input int k);
    return (k == 2) ? 8 : ((k == 3) ? 4 : 0);
  endfunction

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic clr_inputs();
    for (int k = 0; k < 4; k++) begin
      req_d[k] = 4'b0;
      end_d[k] = 4'b0;
    end
  endtask

  // One clock edge of the arbitration rules, applied to the model of config k.
  task automatic model_step(input int k, input logic [3:0] rq, input logic [3:0] en);
    bit ended, to_hit;
    int w, c;
    ended  = (own[k] >= 0) && en[own[k]];
    to_hit = (own[k] >= 0) && (to_of(k) > 0) && (held[k] == to_of(k));
    mto[k] = to_hit && !ended;
    if (own[k] < 0 || ended || to_hit) begin
      w = -1;
      for (int j = 0; j < 4; j++) begin
        c = (mode_of(k) == 1) ? ((last[k] + 1 + j) % 4) : j;
        if (w < 0 && rq[c]) w = c;
      end
      own[k] = w;
      if (w >= 0) begin
        last[k] = w;
        held[k] = 1;
      end
    end else begin
      held[k] = held[k] + 1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clr_inputs();
    repeat (3) cyc();
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if ({gv[k], vld[k], gid[k], tmo[k]} !== 8'b0)
        $display("FAIL reset_outputs dut%0d got gv=%b vld=%b id=%0d to=%b want all zero", k, gv[k], vld[k], gid[k], tmo[k]);
      else n_pass++;
    end
    rst_n = 1'b1;
    repeat (2) cyc();
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if ({gv[k], vld[k], gid[k]} !== 7'b0)
        $display("FAIL idle_no_req dut%0d got gv=%b vld=%b want zero", k, gv[k], vld[k]);
      else n_pass++;
    end
  endtask

  task automatic test_strict_regrant();
    req_d[0] = 4'b1010;
    cyc();
    n_checks++;
    if ({gv[0], vld[0], gid[0]} !== {4'b0010, 1'b1, 2'd1})
      $display("FAIL strict_first got gv=%b vld=%b id=%0d want 0010/1/1", gv[0], vld[0], gid[0]);
    else n_pass++;
    end_d[0] = 4'b0010;
    cyc();
    end_d[0] = 4'b0000;
    n_checks++;
    if ({gv[0], vld[0], gid[0]} !== {4'b0010, 1'b1, 2'd1})
      $display("FAIL strict_regrant got gv=%b vld=%b id=%0d want 0010/1/1", gv[0], vld[0], gid[0]);
    else n_pass++;
    req_d[0] = 4'b0000;
    end_d[0] = 4'b0010;
    cyc();
    end_d[0] = 4'b0000;
    n_checks++;
    if ({gv[0], vld[0], gid[0]} !== 7'b0)
      $display("FAIL strict_release got gv=%b vld=%b id=%0d want zero", gv[0], vld[0], gid[0]);
    else n_pass++;
  endtask

  task automatic test_ignore_end();
    req_d[0] = 4'b0100;
    cyc();
    req_d[0] = 4'b0000;
    end_d[0] = 4'b1001;
    cyc();
    n_checks++;
    if ({gv[0], vld[0], gid[0]} !== {4'b0100, 1'b1, 2'd2})
      $display("FAIL ignore_foreign_end got gv=%b vld=%b id=%0d want 0100/1/2", gv[0], vld[0], gid[0]);
    else n_pass++;
    end_d[0] = 4'b0100;
    cyc();
    end_d[0] = 4'b0000;
    n_checks++;
    if ({gv[0], vld[0], gid[0]} !== 7'b0)
      $display("FAIL owner_end_to_idle got gv=%b vld=%b id=%0d want zero", gv[0], vld[0], gid[0]);
    else n_pass++;
  endtask

  task automatic test_rr_sequence();
    logic [3:0] expv [5];
    expv[0] = 4'b0001; expv[1] = 4'b0010; expv[2] = 4'b0100;
    expv[3] = 4'b1000; expv[4] = 4'b0001;
    req_d[1] = 4'b1111;
    cyc();
    for (int s = 0; s < 5; s++) begin
      n_checks++;
      if ({gv[1], vld[1]} !== {expv[s], 1'b1})
        $display("FAIL rr_step%0d got gv=%b vld=%b want %b/1", s, gv[1], vld[1], expv[s]);
      else n_pass++;
      end_d[1] = expv[s];
      if (s == 4) req_d[1] = 4'b0000;
      cyc();
    end
    end_d[1] = 4'b0000;
    n_checks++;
    if ({gv[1], vld[1]} !== 5'b0)
      $display("FAIL rr_release got gv=%b vld=%b want zero", gv[1], vld[1]);
    else n_pass++;
  endtask

  task automatic test_timeout();
    req_d[2] = 4'b0001;
    cyc();
    for (int c = 1; c <= 10; c++) begin
      n_checks++;
      if ({gv[2], tmo[2]} !== {4'b0001, (c == 9) ? 1'b1 : 1'b0})
        $display("FAIL timeout_cycle%0d got gv=%b to=%b want 0001/%0d", c, gv[2], tmo[2], (c == 9));
      else n_pass++;
      cyc();
    end
    req_d[2] = 4'b0000;
    end_d[2] = 4'b0001;
    cyc();
    end_d[2] = 4'b0000;
    n_checks++;
    if ({gv[2], vld[2], tmo[2]} !== 6'b0)
      $display("FAIL timeout_cleanup got gv=%b vld=%b to=%b want zero", gv[2], vld[2], tmo[2]);
    else n_pass++;
  endtask

  task automatic test_coincide_and_reset();
    // End-of-access on the 4th cycle of a TIMEOUT=4 grant: normal release.
    req_d[3] = 4'b0010;
    cyc();
    n_checks++;
    if (gv[3] !== 4'b0010)
      $display("FAIL coincide_grant got gv=%b want 0010", gv[3]);
    else n_pass++;
    req_d[3] = 4'b0000;
    repeat (3) cyc();
    end_d[3] = 4'b0010;
    cyc();
    end_d[3] = 4'b0000;
    n_checks++;
    if ({gv[3], vld[3], tmo[3]} !== 6'b0)
      $display("FAIL coincide_no_timeout got gv=%b vld=%b to=%b want zero", gv[3], vld[3], tmo[3]);
    else n_pass++;
    // Pure timeout with nothing waiting: grant drops and the pulse fires.
    req_d[3] = 4'b0100;
    cyc();
    req_d[3] = 4'b0000;
    repeat (3) cyc();
    n_checks++;
    if ({gv[3], tmo[3]} !== {4'b0100, 1'b0})
      $display("FAIL timeout4_held got gv=%b to=%b want 0100/0", gv[3], tmo[3]);
    else n_pass++;
    cyc();
    n_checks++;
    if ({gv[3], vld[3], tmo[3]} !== {4'b0000, 1'b0, 1'b1})
      $display("FAIL timeout4_pulse got gv=%b vld=%b to=%b want 0000/0/1", gv[3], vld[3], tmo[3]);
    else n_pass++;
    cyc();
    n_checks++;
    if (tmo[3] !== 1'b0)
      $display("FAIL timeout4_one_cycle got to=%b want 0", tmo[3]);
    else n_pass++;
    // Reset mid-grant clears outputs without a clock edge.
    req_d[3] = 4'b0100;
    cyc();
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({gv[3], vld[3], gid[3]} !== 7'b0)
      $display("FAIL async_reset got gv=%b vld=%b id=%0d want zero", gv[3], vld[3], gid[3]);
    else n_pass++;
    req_d[3] = 4'b1111;
    cyc();
    rst_n = 1'b1;
    cyc();
    n_checks++;
    if ({gv[3], gid[3]} !== {4'b0001, 2'd0})
      $display("FAIL rr_after_reset got gv=%b id=%0d want 0001/0", gv[3], gid[3]);
    else n_pass++;
    clr_inputs();
    end_d[3] = 4'b0001;
    cyc();
    end_d[3] = 4'b0000;
  endtask

  task automatic test_random();
    logic [3:0] rq, en, ev;
    #2 rst_n = 1'b0;
    clr_inputs();
    cyc();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      own[k] = -1; held[k] = 0; last[k] = 3; mto[k] = 1'b0;
    end
    for (int n = 0; n < 600; n++) begin
      for (int k = 0; k < 4; k++) begin
        ev = (own[k] >= 0) ? (4'b0001 << own[k]) : 4'b0000;
        n_checks++;
        if ({gv[k], vld[k], gid[k], tmo[k]} !== {ev, own[k] >= 0, (own[k] >= 0) ? 2'(own[k]) : 2'd0, mto[k]})
          $display("FAIL random dut%0d cyc%0d got gv=%b vld=%b id=%0d to=%b want gv=%b to=%b",
                   k, n, gv[k], vld[k], gid[k], tmo[k], ev, mto[k]);
        else n_pass++;
      end
      for (int k = 0; k < 4; k++) begin
        rq = ($urandom_range(0, 4) == 0) ? 4'b0000 : 4'($urandom);
        en = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
        req_d[k] = rq;
        end_d[k] = en;
        model_step(k, rq, en);
      end
      cyc();
    end
    clr_inputs();
  endtask

  initial begin
    rst_n = 1'b0;
    clr_inputs();
    test_reset();
    test_strict_regrant();
    test_ignore_end();
    test_rr_sequence();
    test_timeout();
    test_coincide_and_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
